cursor_grid_ctrl: RTL and testbench

//  Parametrised, clocked successor to the static grid painter. Owns a movable cursor

---
 rtl/cursor_grid_ctrl_pkg.sv | 19 +
 rtl/cursor_grid_ctrl_btn_debounce.sv | 49 ++++
 rtl/cursor_grid_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cursor_grid_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_grid_ctrl_pkg.sv
// Shared definitions for the cursor grid controller: default colours,
// cursor move directions and the cell-index width.
package cursor_pkg;

  localparam int CELL_IDX_W = 6;

  localparam logic [23:0] COL_LINE_DEF   = 24'hFFFFFF;
  localparam logic [23:0] COL_CELL_DEF   = 24'h878080;
  localparam logic [23:0] COL_CURSOR_DEF = 24'hF54927;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

endpackage

// File: rtl/cursor_grid_ctrl_btn_debounce.sv
// Push-button debouncer: accepts a new level after DEBOUNCE_CYC consecutive
// cycles of disagreement and pulses press for one cycle on an accepted rise.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int            CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (raw != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = raw;
        press_d = raw;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/cursor_grid_ctrl.sv
// Board grid renderer with a button-driven, blinking cursor cell.
// Colour output is registered with a fixed two-cycle latency.
module cursor_grid_ctrl
  import cursor_pkg::*;
#(
  parameter int          GRID_W       = 16,
  parameter int          GRID_H       = 16,
  parameter int          CELL_W       = 40,
  parameter int          CELL_H       = 30,
  parameter int          WRAP         = 1,
  parameter int          DEBOUNCE_CYC = 500000,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [23:0] COL_LINE     = cursor_pkg::COL_LINE_DEF,
  parameter logic [23:0] COL_CELL     = cursor_pkg::COL_CELL_DEF,
  parameter logic [23:0] COL_CURSOR   = cursor_pkg::COL_CURSOR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            xPixel,
  input  logic [9:0]            yPixel,
  input  logic                  active_pixels,
  input  logic                  frame_start,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_left,
  input  logic                  btn_right,
  output logic [CELL_IDX_W-1:0] cursor_x,
  output logic [CELL_IDX_W-1:0] cursor_y,
  output logic [23:0]           vga_color
);

  localparam logic [CELL_IDX_W-1:0] X_MAX      = CELL_IDX_W'(GRID_W - 1);
  localparam logic [CELL_IDX_W-1:0] Y_MAX      = CELL_IDX_W'(GRID_H - 1);
  localparam logic [7:0]            BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [9:0]            CELL_W_P   = 10'(CELL_W);
  localparam logic [9:0]            CELL_H_P   = 10'(CELL_H);
  localparam logic [9:0]            GRID_W_P   = 10'(GRID_W);
  localparam logic [9:0]            GRID_H_P   = 10'(GRID_H);

  // Button index order: 0 up, 1 down, 2 left, 3 right.
  logic [3:0] btn_raw;
  logic [3:0] btn_press;
  logic [3:0] btn_level_unused;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_debounce (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (btn_level_unused[i]),
      .press (btn_press[i])
    );
  end

  dir_e                  dir;
  logic [CELL_IDX_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [7:0]            blink_cnt_q, blink_cnt_d;
  logic                  blink_on_q, blink_on_d;

  always_comb begin
    dir = DIR_NONE;
    if      (btn_press[0]) dir = DIR_UP;
    else if (btn_press[1]) dir = DIR_DOWN;
    else if (btn_press[2]) dir = DIR_LEFT;
    else if (btn_press[3]) dir = DIR_RIGHT;
  end

  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    case (dir)
      DIR_UP:    if (cur_y_q != '0)    cur_y_d = cur_y_q - 1'b1;
                 else if (WRAP != 0)   cur_y_d = Y_MAX;
      DIR_DOWN:  if (cur_y_q != Y_MAX) cur_y_d = cur_y_q + 1'b1;
                 else if (WRAP != 0)   cur_y_d = '0;
      DIR_LEFT:  if (cur_x_q != '0)    cur_x_d = cur_x_q - 1'b1;
                 else if (WRAP != 0)   cur_x_d = X_MAX;
      DIR_RIGHT: if (cur_x_q != X_MAX) cur_x_d = cur_x_q + 1'b1;
                 else if (WRAP != 0)   cur_x_d = '0;
      default: ;
    endcase
  end

  // A move restarts the blink so the cursor stays visible while moving.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (dir != DIR_NONE) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (frame_start) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  logic [9:0]  s1_cx_q, s1_cy_q, s1_lx_q, s1_ly_q;
  logic [9:0]  s1_cx_d, s1_cy_d, s1_lx_d, s1_ly_d;
  logic        s1_act_q, s1_inb_q, s1_inb_d;
  logic [23:0] color_q, color_d;

  always_comb begin
    s1_cx_d  = xPixel / CELL_W_P;
    s1_cy_d  = yPixel / CELL_H_P;
    s1_lx_d  = xPixel % CELL_W_P;
    s1_ly_d  = yPixel % CELL_H_P;
    s1_inb_d = (s1_cx_d < GRID_W_P) && (s1_cy_d < GRID_H_P);
  end

  always_comb begin
    color_d = '0;
    if (s1_act_q && s1_inb_q) begin
      if (s1_lx_q == '0 || s1_ly_q == '0)
        color_d = COL_LINE;
      else if (s1_cx_q == 10'(cur_x_q) && s1_cy_q == 10'(cur_y_q) && blink_on_q)
        color_d = COL_CURSOR;
      else
        color_d = COL_CELL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      s1_cx_q     <= '0;
      s1_cy_q     <= '0;
      s1_lx_q     <= '0;
      s1_ly_q     <= '0;
      s1_act_q    <= 1'b0;
      s1_inb_q    <= 1'b0;
      color_q     <= '0;
    end else begin
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      s1_cx_q     <= s1_cx_d;
      s1_cy_q     <= s1_cy_d;
      s1_lx_q     <= s1_lx_d;
      s1_ly_q     <= s1_ly_d;
      s1_act_q    <= active_pixels;
      s1_inb_q    <= s1_inb_d;
      color_q     <= color_d;
    end
  end

  assign cursor_x  = cur_x_q;
  assign cursor_y  = cur_y_q;
  assign vga_color = color_q;

endmodule

// File: tb/tb_cursor_grid_ctrl.sv
// Bench for cursor_grid_ctrl: a wrapping and a saturating instance share all
// inputs and are checked every cycle against a behavioural model.
module tb_cursor_grid_ctrl;

  localparam int GW = 16, GH = 16, CW = 40, CH = 30, DC = 4, BF = 2;

  logic       clk = 1'b0;
  logic       rst, act, fs, bu, bd, bl, br;
  logic [9:0] xp, yp;
  logic [5:0] cx_w, cy_w, cx_s, cy_s;
  logic [23:0] col_w, col_s;

  always #5 clk = ~clk;

  cursor_grid_ctrl #(.WRAP(1), .DEBOUNCE_CYC(DC), .BLINK_FRAMES(BF)) dut_w (
    .clk(clk), .rst(rst), .xPixel(xp), .yPixel(yp), .active_pixels(act),
    .frame_start(fs), .btn_up(bu), .btn_down(bd), .btn_left(bl), .btn_right(br),
    .cursor_x(cx_w), .cursor_y(cy_w), .vga_color(col_w));

  cursor_grid_ctrl #(.WRAP(0), .DEBOUNCE_CYC(DC), .BLINK_FRAMES(BF)) dut_s (
    .clk(clk), .rst(rst), .xPixel(xp), .yPixel(yp), .active_pixels(act),
    .frame_start(fs), .btn_up(bu), .btn_down(bd), .btn_left(bl), .btn_right(br),
    .cursor_x(cx_s), .cursor_y(cy_s), .vga_color(col_s));

  int checks = 0;
  int errors = 0;

  // Model state; index k: 0 = wrapping instance, 1 = saturating instance.
  int acc[4];
  bit pend[4];
  int hist[4][$];
  int mx[2], my[2];
  int bcnt;
  bit bon;
  int s1x, s1y;
  bit s1a;
  logic [23:0] ecol[2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [23:0] colour(int x, int y, bit a, int cx, int cy, bit on);
    int xc = x / CW;
    int yc = y / CH;
    if (!a || xc >= GW || yc >= GH) return 24'h000000;
    if (x % CW == 0 || y % CH == 0) return 24'hFFFFFF;
    if (xc == cx && yc == cy && on) return 24'hF54927;
    return 24'h878080;
  endfunction

  function automatic int step_coord(int v, int delta, int lim, bit wrap);
    int n = v + delta;
    if (wrap) return (n + lim) % lim;
    if (n < 0) return 0;
    if (n > lim - 1) return lim - 1;
    return n;
  endfunction

  task automatic model_step();
    bit raw[4];
    int d;
    raw[0] = bu; raw[1] = bd; raw[2] = bl; raw[3] = br;
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        acc[b] = 0; pend[b] = 0; hist[b].delete();
      end
      for (int k = 0; k < 2; k++) begin
        mx[k] = 0; my[k] = 0; ecol[k] = '0;
      end
      bcnt = 0; bon = 1; s1x = 0; s1y = 0; s1a = 0;
    end else begin
      for (int k = 0; k < 2; k++) ecol[k] = colour(s1x, s1y, s1a, mx[k], my[k], bon);
      s1x = xp; s1y = yp; s1a = act;
      d = pend[0] ? 0 : pend[1] ? 1 : pend[2] ? 2 : pend[3] ? 3 : -1;
      if (d >= 0) begin
        for (int k = 0; k < 2; k++) begin
          if (d == 0) my[k] = step_coord(my[k], -1, GH, k == 0);
          if (d == 1) my[k] = step_coord(my[k], 1, GH, k == 0);
          if (d == 2) mx[k] = step_coord(mx[k], -1, GW, k == 0);
          if (d == 3) mx[k] = step_coord(mx[k], 1, GW, k == 0);
        end
        bcnt = 0; bon = 1;
      end else if (fs) begin
        if (bcnt == BF - 1) begin bcnt = 0; bon = !bon; end
        else bcnt++;
      end
      // A level is accepted once the last DC raw samples all agree and differ from it.
      for (int b = 0; b < 4; b++) begin
        bit same = 1;
        hist[b].push_back(int'(raw[b]));
        if (hist[b].size() > DC) void'(hist[b].pop_front());
        pend[b] = 0;
        foreach (hist[b][i]) if (hist[b][i] != int'(raw[b])) same = 0;
        if (hist[b].size() == DC && same && int'(raw[b]) != acc[b]) begin
          acc[b] = int'(raw[b]);
          pend[b] = raw[b];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("cx_wrap", 32'(cx_w), 32'(mx[0]));
    check("cy_wrap", 32'(cy_w), 32'(my[0]));
    check("cx_sat", 32'(cx_s), 32'(mx[1]));
    check("cy_sat", 32'(cy_s), 32'(my[1]));
    check("col_wrap", 32'(col_w), 32'(ecol[0]));
    check("col_sat", 32'(col_s), 32'(ecol[1]));
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bu = v;
      1: bd = v;
      2: bl = v;
      default: br = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    repeat (DC + 2) tick();
    set_btn(b, 1'b0);
    repeat (DC + 2) tick();
  endtask

  task automatic do_reset();
    bu = 0; bd = 0; bl = 0; br = 0; fs = 0;
    rst = 1;
    repeat (3) tick();
    rst = 0;
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        a;
    logic [23:0] col;
  } vec_t;

  vec_t vt[5];
  int   hold[4];

  initial begin
    vt[0] = '{x: 10'd45, y: 10'd10, a: 1'b1, col: 24'hF54927};
    vt[1] = '{x: 10'd40, y: 10'd10, a: 1'b1, col: 24'hFFFFFF};
    vt[2] = '{x: 10'd85, y: 10'd10, a: 1'b1, col: 24'h878080};
    vt[3] = '{x: 10'd45, y: 10'd10, a: 1'b0, col: 24'h000000};
    vt[4] = '{x: 10'd700, y: 10'd10, a: 1'b1, col: 24'h000000};

    xp = 10'd100; yp = 10'd100; act = 1; fs = 0;
    bu = 0; bd = 0; bl = 0; br = 0;
    rst = 1;
    repeat (2) tick();
    rst = 0;

    // Reset in the middle of a debounce and a frame.
    press(3);
    br = 1; fs = 1;
    repeat (2) tick();
    fs = 0; br = 0;
    rst = 1;
    repeat (3) tick();
    rst = 0;
    tick();
    check("rst_cx", 32'(cx_w), 0);
    check("rst_cy", 32'(cy_w), 0);
    check("rst_col", 32'(col_w), 0);

    // Short pulse is ignored; long hold moves exactly once.
    br = 1; repeat (3) tick();
    br = 0; repeat (6) tick();
    check("short_press_x", 32'(cx_w), 0);
    br = 1; repeat (100) tick();
    br = 0; repeat (6) tick();
    check("held_press_x", 32'(cx_w), 1);
    check("held_press_x_sat", 32'(cx_s), 1);

    // Edge behaviour.
    do_reset();
    press(2);
    check("left_wrap_x", 32'(cx_w), 15);
    check("left_sat_x", 32'(cx_s), 0);
    do_reset();
    for (int i = 0; i < 15; i++) press(3);
    for (int i = 0; i < 15; i++) press(1);
    check("corner_x", 32'(cx_s), 15);
    check("corner_y", 32'(cy_w), 15);
    press(1);
    check("down_wrap_y", 32'(cy_w), 0);
    check("down_sat_y", 32'(cy_s), 15);
    press(3);
    check("right_wrap_x", 32'(cx_w), 0);
    check("right_sat_x", 32'(cx_s), 15);

    // Simultaneous up and right: up wins.
    do_reset();
    for (int i = 0; i < 5; i++) press(3);
    for (int i = 0; i < 5; i++) press(1);
    bu = 1; br = 1;
    repeat (DC + 2) tick();
    bu = 0; br = 0;
    repeat (DC + 2) tick();
    check("prio_x", 32'(cx_w), 5);
    check("prio_y", 32'(cy_w), 4);

    // Pixel colours with cursor at (1,0).
    do_reset();
    press(3);
    foreach (vt[i]) begin
      xp = vt[i].x; yp = vt[i].y; act = vt[i].a;
      repeat (2) tick();
      check($sformatf("vec%0d_col", i), 32'(col_w), 32'(vt[i].col));
    end

    // Blink off after two frames, forced back on by a press.
    act = 1; xp = 10'd45; yp = 10'd10;
    repeat (2) begin
      fs = 1; tick();
      fs = 0; tick();
    end
    repeat (2) tick();
    check("blink_off_col", 32'(col_w), 24'h878080);
    xp = 10'd85;
    press(3);
    repeat (2) tick();
    check("blink_forced_col", 32'(col_w), 24'hF54927);

    // Randomised traffic against the model.
    for (int b = 0; b < 4; b++) hold[b] = 0;
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          set_btn(b, 1'($urandom_range(0, 1)));
          hold[b] = int'($urandom_range(1, 10));
        end
        hold[b]--;
      end
      xp  = 10'($urandom_range(0, 1023));
      yp  = 10'($urandom_range(0, 1023));
      act = ($urandom_range(0, 9) != 0);
      fs  = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
